// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Data-bus request/ack channel between the load/store unit
//               (master) and the memory system (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store unit: byte-lane alignment, req/ack bus handshake
//               with timeout, and sign/zero-extended load writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [2:0]         funct3_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  input  logic [4:0]         rd_i,
  mem_access_unit_if.master  bus,
  output logic [31:0]        reg_wdata_o,
  output logic [4:0]         reg_waddr_o,
  output logic               reg_wen_o,
  output logic               hold_flag_o,
  output logic               misalign_o,
  output logic               bus_err_o
);

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [1:0]  r_shift;

  logic        w_supported;
  logic        w_aligned;
  logic        w_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load;

  // Unsupported encodings are folded into the misaligned path.
  always_comb begin
    w_supported = 1'b0;
    w_aligned   = 1'b0;
    case (funct3_i)
      c_F3_B: begin
        w_supported = 1'b1;
        w_aligned   = 1'b1;
      end
      c_F3_H: begin
        w_supported = 1'b1;
        w_aligned   = ~addr_i[0];
      end
      c_F3_W: begin
        w_supported = 1'b1;
        w_aligned   = (addr_i[1:0] == 2'b00);
      end
      c_F3_BU: begin
        w_supported = ~we_i;
        w_aligned   = 1'b1;
      end
      c_F3_HU: begin
        w_supported = ~we_i;
        w_aligned   = ~addr_i[0];
      end
      default: begin
        w_supported = 1'b0;
        w_aligned   = 1'b0;
      end
    endcase
  end

  assign w_ok = w_supported & w_aligned;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    if (we_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr_i[1:0];
          w_wdata = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << addr_i[1:0];
          w_wdata = {2{wdata_i[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = wdata_i;
        end
      endcase
    end
  end

  assign w_lane = bus.bus_rdata_i >> {r_shift, 3'b000};

  always_comb begin
    case (r_funct3)
      c_F3_B:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      c_F3_H:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      c_F3_BU: w_load = {24'h000000, w_lane[7:0]};
      c_F3_HU: w_load = {16'h0000, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  assign hold_flag_o = (r_state == S_REQ) || ((r_state == S_IDLE) && req_i && w_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= 8'd0;
      r_funct3        <= 3'd0;
      r_rd            <= 5'd0;
      r_shift         <= 2'd0;
      bus.bus_req_o   <= 1'b0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_addr_o  <= 32'd0;
      bus.bus_be_o    <= 4'd0;
      bus.bus_wdata_o <= 32'd0;
      reg_wdata_o     <= 32'd0;
      reg_waddr_o     <= 5'd0;
      reg_wen_o       <= 1'b0;
      misalign_o      <= 1'b0;
      bus_err_o       <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      reg_wen_o  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            if (w_ok) begin
              bus.bus_req_o   <= 1'b1;
              bus.bus_we_o    <= we_i;
              bus.bus_addr_o  <= {addr_i[31:2], 2'b00};
              bus.bus_be_o    <= w_be;
              bus.bus_wdata_o <= w_wdata;
              r_funct3        <= funct3_i;
              r_rd            <= rd_i;
              r_shift         <= addr_i[1:0];
              r_cnt           <= 8'd0;
              r_state         <= S_REQ;
            end else begin
              misalign_o <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // Ack is tested first so a last-cycle ack still completes.
          if (bus.bus_ack_i) begin
            bus.bus_req_o <= 1'b0;
            if (!bus.bus_we_o) begin
              reg_wdata_o <= w_load;
              reg_waddr_o <= r_rd;
              reg_wen_o   <= (r_rd != 5'd0);
            end
            r_state <= S_DONE;
          end else if (r_cnt == c_CNT_LAST) begin
            bus.bus_req_o <= 1'b0;
            bus_err_o     <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a random-latency
//               bus responder and a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int c_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [4:0]  rd_i = 5'd0;
  logic [31:0] reg_wdata_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_wen_o;
  logic        hold_flag_o;
  logic        misalign_o;
  logic        bus_err_o;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(c_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .we_i        (we_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rd_i        (rd_i),
    .bus         (bus_if),
    .reg_wdata_o (reg_wdata_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wen_o   (reg_wen_o),
    .hold_flag_o (hold_flag_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } bus_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
  } ack_t;

  bus_t       exp_bus_q[$];
  wb_t        exp_wb_q[$];
  ack_t       ack_q[$];
  logic [7:0] exp_evt_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: describes accesses as byte lanes within a word.
  function automatic bit legal(input bit we, input bit [2:0] f3, input bit [31:0] a);
    case (f3)
      3'd0:    return 1'b1;
      3'd1:    return a[0] == 1'b0;
      3'd2:    return a[1:0] == 2'b00;
      3'd4:    return !we;
      3'd5:    return !we && (a[0] == 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int size_of(input bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] model_be(input bit we, input bit [2:0] f3, input int s);
    logic [3:0] be;
    be = 4'b0000;
    for (int i = 0; i < 4; i++)
      be[i] = !we || ((i >= s) && (i < s + size_of(f3)));
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input bit [2:0] f3, input bit [31:0] w);
    logic [31:0] r;
    int sz;
    sz = size_of(f3);
    r = 32'd0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = w[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input bit [2:0] f3, input int s, input bit [31:0] rdata);
    longint v;
    int     bits;
    bits = 8 * size_of(f3);
    v = longint'(rdata) >> (8 * s);
    v = v & ((64'sd1 <<< bits) - 1);
    if (!f3[2] && bits < 32 && v[bits-1]) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  // Bus responder: ack on the delay-th cycle of bus_req (never if delay > TIMEOUT).
  initial begin
    int   cnt;
    bit   busy;
    ack_t cur;
    busy = 1'b0;
    cnt  = 0;
    cur  = '{100, 32'd0};
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = 32'd0;
    forever begin
      @(negedge clk);
      if (!bus_if.bus_req_o || !rst) begin
        busy = 1'b0;
        bus_if.bus_ack_i = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          if (ack_q.size() > 0) cur = ack_q.pop_front();
          else cur = '{100, 32'd0};
        end
        cnt++;
        if (cnt == cur.delay) begin
          bus_if.bus_ack_i   = 1'b1;
          bus_if.bus_rdata_i = cur.rdata;
        end else begin
          bus_if.bus_ack_i   = 1'b0;
          bus_if.bus_rdata_i = $urandom;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a bus request,
  // writeback, or error pulse.
  initial begin
    bit          in_txn;
    int          len;
    bus_t        cur;
    wb_t         wb;
    logic [7:0]  ev;
    logic [31:0] first_addr, first_wdata;
    logic [3:0]  first_be;
    in_txn = 1'b0;
    len    = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_txn = 1'b0;
      end else begin
        if (bus_if.bus_req_o) begin
          chk("hold_in_req", {31'd0, hold_flag_o}, 32'd1);
          if (!in_txn) begin
            in_txn = 1'b1;
            len    = 1;
            first_addr  = bus_if.bus_addr_o;
            first_be    = bus_if.bus_be_o;
            first_wdata = bus_if.bus_wdata_o;
            chk("bus_req_expected", {31'd0, exp_bus_q.size() > 0}, 32'd1);
            if (exp_bus_q.size() > 0) begin
              cur = exp_bus_q.pop_front();
              chk("bus_addr", bus_if.bus_addr_o, cur.addr);
              chk("bus_be", {28'd0, bus_if.bus_be_o}, {28'd0, cur.be});
              chk("bus_we", {31'd0, bus_if.bus_we_o}, {31'd0, cur.we});
              if (cur.we) chk("bus_wdata", bus_if.bus_wdata_o, cur.wdata);
            end
          end else begin
            len++;
            chk("bus_stable", {bus_if.bus_addr_o ^ first_addr} | {28'd0, bus_if.bus_be_o ^ first_be}
                              | (bus_if.bus_wdata_o ^ first_wdata), 32'd0);
          end
        end else if (in_txn) begin
          in_txn = 1'b0;
          chk("bus_req_cycles", len, cur.len);
        end
        if (reg_wen_o) begin
          chk("hold_in_done", {31'd0, hold_flag_o}, 32'd0);
          chk("wb_expected", {31'd0, exp_wb_q.size() > 0}, 32'd1);
          if (exp_wb_q.size() > 0) begin
            wb = exp_wb_q.pop_front();
            chk("reg_waddr", {27'd0, reg_waddr_o}, {27'd0, wb.rd});
            chk("reg_wdata", reg_wdata_o, wb.data);
          end
        end
        if (misalign_o || bus_err_o) begin
          chk("event_expected", {31'd0, exp_evt_q.size() > 0}, 32'd1);
          if (exp_evt_q.size() > 0) begin
            ev = exp_evt_q.pop_front();
            chk("event_kind", {24'd0, misalign_o ? 8'h4D : 8'h45}, {24'd0, ev});
          end
          chk("single_event", {31'd0, misalign_o & bus_err_o}, 32'd0);
        end
      end
    end
  end

  task automatic access(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        input bit [4:0] rd, input int delay, input bit [31:0] rdata);
    bit   ok;
    int   s;
    bus_t b;
    ok = legal(we, f3, a);
    s  = int'(a[1:0]);
    @(negedge clk);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd; rd_i = rd;
    if (ok) begin
      b.addr  = {a[31:2], 2'b00};
      b.be    = model_be(we, f3, s);
      b.we    = we;
      b.wdata = model_wdata(f3, wd);
      b.len   = (delay <= c_TIMEOUT) ? delay : c_TIMEOUT;
      exp_bus_q.push_back(b);
      ack_q.push_back('{delay, rdata});
      if (delay > c_TIMEOUT) exp_evt_q.push_back(8'h45);
      else if (!we && rd != 5'd0) exp_wb_q.push_back('{rd, model_load(f3, s, rdata)});
    end else begin
      exp_evt_q.push_back(8'h4D);
    end
    #1 chk("hold_on_accept", {31'd0, hold_flag_o}, {31'd0, ok});
    @(negedge clk);
    req_i = 1'b0;
    if (ok) begin
      for (int i = 0; i < 40 && bus_if.bus_req_o; i++) @(negedge clk);
      chk("bus_req_released", {31'd0, bus_if.bus_req_o}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bus_req"},   {31'd0, bus_if.bus_req_o}, 32'd0);
    chk({tag, "_bus_we"},    {31'd0, bus_if.bus_we_o}, 32'd0);
    chk({tag, "_bus_addr"},  bus_if.bus_addr_o, 32'd0);
    chk({tag, "_bus_be"},    {28'd0, bus_if.bus_be_o}, 32'd0);
    chk({tag, "_bus_wdata"}, bus_if.bus_wdata_o, 32'd0);
    chk({tag, "_reg_wdata"}, reg_wdata_o, 32'd0);
    chk({tag, "_reg_waddr"}, {27'd0, reg_waddr_o}, 32'd0);
    chk({tag, "_pulses"},    {29'd0, reg_wen_o, misalign_o, bus_err_o}, 32'd0);
    chk({tag, "_hold"},      {31'd0, hold_flag_o}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 check_all_zero("in_reset");
    rst = 1'b1;
    @(negedge clk);
    #1 check_all_zero("after_reset");

    access(1'b0, 3'd2, 32'h0000_0104, 32'd0, 5'd5, 3, 32'hDEAD_BEEF);
    access(1'b0, 3'd0, 32'h0000_0107, 32'd0, 5'd6, 2, 32'h80FF_1234);
    access(1'b0, 3'd4, 32'h0000_0107, 32'd0, 5'd7, 1, 32'h80FF_1234);
    access(1'b1, 3'd1, 32'h0000_0022, 32'h0000_ABCD, 5'd9, 2, 32'd0);
    access(1'b0, 3'd2, 32'h0000_0103, 32'd0, 5'd5, 2, 32'd0);
    access(1'b1, 3'd4, 32'h0000_0100, 32'd0, 5'd5, 2, 32'd0);
    access(1'b0, 3'd3, 32'h0000_0100, 32'd0, 5'd5, 2, 32'd0);
    access(1'b0, 3'd2, 32'h0000_0200, 32'd0, 5'd8, 100, 32'd0);
    access(1'b0, 3'd2, 32'h0000_0204, 32'd0, 5'd8, c_TIMEOUT, 32'h1234_5678);
    access(1'b0, 3'd5, 32'h0000_0302, 32'd0, 5'd0, 1, 32'h8001_7FFF);

    // Reset in the middle of a load: no writeback may follow.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h0000_0400; rd_i = 5'd11;
    exp_bus_q.push_back('{32'h0000_0400, 4'hF, 1'b0, 32'd0, 0});
    ack_q.push_back('{100, 32'hCAFE_F00D});
    @(negedge clk);
    req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    access(1'b1, 3'd0, 32'h0000_0003, 32'h0000_005A, 5'd1, 2, 32'd0);

    for (int n = 0; n < 200; n++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 31)), int'($urandom_range(1, 20)), $urandom);
    end

    repeat (4) @(negedge clk);
    chk("bus_q_drained", exp_bus_q.size(), 32'd0);
    chk("wb_q_drained",  exp_wb_q.size(), 32'd0);
    chk("evt_q_drained", exp_evt_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit directly downstream of the execute stage.
- Takes one memory request per access: effective address, store data, funct3 and destination register.
- Performs byte-lane alignment and a req/ack handshake with the data bus, then returns sign/zero-extended load data for register writeback.
- Stalls the pipeline through the ctrl block for the whole access.

Parameters:
- TIMEOUT, 16: maximum cycles in REQ without bus_ack_i before the access is aborted. Legal range 2..255.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- req_i  input  1  execute stage presents a memory access this cycle
- we_i  input  1  1 = store, 0 = load
- funct3_i  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are valid for loads only
- addr_i  input  32  effective byte address
- wdata_i  input  32  store data, right-justified (byte/half in the low bits)
- rd_i  input  5  load destination register
- bus_req_o  output  1  bus request
- bus_we_o  output  1  bus write
- bus_addr_o  output  32  word-aligned address, addr[31:2] with 2'b00 appended
- bus_be_o  output  4  byte enables
- bus_wdata_o  output  32  lane-shifted store data
- bus_ack_i  input  1  bus completion (single-cycle pulse)
- bus_rdata_i  input  32  read word, valid when bus_ack_i=1
- reg_wdata_o  output  32  load result
- reg_waddr_o  output  5  load destination
- reg_wen_o  output  1  writeback strobe
- hold_flag_o  output  1  pipeline stall request to ctrl
- misalign_o  output  1  one-cycle pulse: misaligned access rejected
- bus_err_o  output  1  one-cycle pulse: bus timeout

Behaviour:
- Reset: every registered output is 0 and the state is IDLE. Reset asserted mid-access aborts immediately; no writeback and no pulses are produced. This applies to bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, reg_wdata_o, reg_waddr_o, reg_wen_o, misalign_o and bus_err_o.
- States: IDLE, REQ, DONE.
- IDLE, req_i=1:
  - Latch all inputs.
  - Alignment rule: H/HU need addr[0]=0; W needs addr[1:0]=0.
  - Misaligned: misalign_o=1 next cycle, stay IDLE, no bus activity, no writeback.
  - Aligned: go to REQ.
- IDLE, req_i ignored while not IDLE.
- Store byte enables (s = addr[1:0]):
  - B: be = 0001 << s, wdata = {4{wdata[7:0]}}.
  - H: be = 0011 << s, wdata = {2{wdata[15:0]}}.
  - W: be = 1111, wdata passed through.
- Load byte enables: be = 1111.
- Unsupported funct3 (011, 110, 111, or BU/HU with we_i=1) is treated as misaligned: pulse misalign_o.
- REQ:
  - bus_req_o=1; bus address, be, we and wdata stay stable until ack.
  - Timeout counter starts at 0 on entry and increments each cycle without ack.
  - bus_ack_i=1: deassert bus_req_o next cycle. For a load, capture the lane (bus_rdata_i >> 8*s), extend it per funct3, and register the result. Go to DONE.
  - Counter reaches TIMEOUT-1 without ack: bus_err_o=1 for one cycle, go to IDLE, no writeback.
  - Ack in the same cycle the counter hits TIMEOUT-1: ack wins.
- DONE:
  - Load with rd≠0: reg_wen_o=1 for exactly one cycle with reg_wdata_o/reg_waddr_o. Otherwise reg_wen_o=0.
  - Always return to IDLE.
  - req_i in DONE is ignored; the upstream stage re-presents it because hold was asserted.
- hold_flag_o (combinational):
  - 1 when in IDLE with req_i=1 and the access is aligned and supported.
  - 1 in REQ.
  - 0 in DONE and otherwise.
- Latency: accept in cycle 0; bus_req_o high from cycle 1; ack in cycle k; writeback in cycle k+1; back in IDLE in cycle k+2.
- Back-to-back: a new req_i accepted in the IDLE cycle directly after DONE.

Test Plan:
- Aligned LW: addr 0x104, ack after 3 cycles, rdata 0xDEADBEEF. Required: bus_addr 0x104, be 1111, one reg_wen pulse with 0xDEADBEEF to rd=5, hold high from accept through the ack cycle.
- LB and LBU at addr 0x107, rdata 0x80FF1234. Required: LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH at addr 0x22, wdata 0x0000ABCD. Required: bus_addr 0x20, be 1100, bus_wdata 0xABCDABCD, bus_we 1, no reg_wen.
- LW at addr 0x103. Required: misalign_o pulse the next cycle, no bus_req, hold low, no reg_wen.
- Timeout with TIMEOUT=16 and no ack. Required: bus_req high for 16 cycles, bus_err_o pulse, back to IDLE, no writeback. A separate case with ack arriving on the 16th cycle completes normally.
- rst driven low during REQ of a load. Required: all outputs 0 immediately, no writeback after release; a following SB at 0x3, wdata 0x5A gives be 1000 and bus_wdata 0x5A5A5A5A.
